// File: rtl/tron_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// tron_mem_arbiter_if
// Bundles the CPU load/store port, the read-only video/DMA port and the
// single-port RAM port that the Tron memory arbiter sits between.
//
// Signals
//   cpuReq/cpuWe/cpuAddr/cpuWdata  CPU request side (level req, held to ack)
//   cpuRdata/cpuAck                CPU response side (registered data, 1-cycle ack)
//   vidReq/vidAddr                 video request side (read only)
//   vidRdata/vidAck                video response side
//   memAddr/memWdata/memWe         RAM command side
//   memRdata                       RAM read data, valid the cycle after its address
//
// Modports
//   master : requesters plus RAM model (drive requests and memRdata)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface tron_mem_arbiter_if;
  logic        cpuReq;
  logic        cpuWe;
  logic [15:0] cpuAddr;
  logic [15:0] cpuWdata;
  logic [15:0] cpuRdata;
  logic        cpuAck;
  logic        vidReq;
  logic [15:0] vidAddr;
  logic [15:0] vidRdata;
  logic        vidAck;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memWe;
  logic [15:0] memRdata;

  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWdata, vidReq, vidAddr, memRdata,
    input  cpuRdata, cpuAck, vidRdata, vidAck, memAddr, memWdata, memWe
  );

  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWdata, vidReq, vidAddr, memRdata,
    output cpuRdata, cpuAck, vidRdata, vidAck, memAddr, memWdata, memWe
  );
endinterface

// File: rtl/tron_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tron_mem_arbiter
// Shares the Tron single-port 16-bit synchronous-read RAM between the CPU
// load/store path and a read-only video/DMA fetch port. Each access is a
// two-cycle sequence: a grant cycle that drives the RAM command, then a
// response cycle that pulses the matching ack while the RAM data is captured
// into that port's read-data register. CPU has priority; a starvation
// counter forces a video win once STARVE_LIMIT CPU grants have been taken
// while video was waiting.
//
// Parameters
//   STARVE_LIMIT  CPU grants tolerated while vidReq waits (1..15)
//
// Ports
//   i_clk    system clock, rising edge
//   i_reset  synchronous reset, ACTIVE LOW
//   io_bus   tron_mem_arbiter_if.slave (CPU, video and RAM ports)
// ---------------------------------------------------------------------------
module tron_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  tron_mem_arbiter_if.slave    io_bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    CPU_GNT,
    VID_GNT,
    CPU_RSP,
    VID_RSP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_starveCnt;
  logic [15:0] r_cpuRdata;
  logic [15:0] r_vidRdata;
  logic [15:0] w_memAddr;
  logic [15:0] w_memWdata;
  logic        w_memWe;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A response state hands straight over to the other
  // requester if it is waiting; the port just served never re-wins here, so
  // a same-port back-to-back access always goes through IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (io_bus.vidReq && (r_starveCnt == LIMIT)) begin
          w_nextState = VID_GNT;
        end else if (io_bus.cpuReq) begin
          w_nextState = CPU_GNT;
        end else if (io_bus.vidReq) begin
          w_nextState = VID_GNT;
        end
      end
      CPU_GNT: w_nextState = CPU_RSP;
      VID_GNT: w_nextState = VID_RSP;
      CPU_RSP: w_nextState = io_bus.vidReq ? VID_GNT : IDLE;
      VID_RSP: w_nextState = io_bus.cpuReq ? CPU_GNT : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // RAM command decode. The write enable is qualified by reset so a reset
  // landing in a CPU grant cycle cannot produce a partial write.
  always_comb begin
    w_memAddr  = 16'h0000;
    w_memWdata = 16'h0000;
    w_memWe    = 1'b0;
    if (r_state == CPU_GNT) begin
      w_memAddr  = io_bus.cpuAddr;
      w_memWdata = io_bus.cpuWdata;
      w_memWe    = io_bus.cpuWe & i_reset;
    end else if (r_state == VID_GNT) begin
      w_memAddr  = io_bus.vidAddr;
    end
  end

  // Starvation counter. Every grant state lasts one cycle, so a next state of
  // CPU_GNT/VID_GNT is always an entry into it.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_starveCnt <= 4'd0;
    end else if (!io_bus.vidReq) begin
      r_starveCnt <= 4'd0;
    end else if (w_nextState == VID_GNT) begin
      r_starveCnt <= 4'd0;
    end else if ((w_nextState == CPU_GNT) && (r_starveCnt != LIMIT)) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

  // Read-data capture at the end of each response cycle. Stores also load
  // the register; the CPU ignores that value.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cpuRdata <= 16'h0000;
      r_vidRdata <= 16'h0000;
    end else begin
      if (r_state == CPU_RSP) begin
        r_cpuRdata <= io_bus.memRdata;
      end
      if (r_state == VID_RSP) begin
        r_vidRdata <= io_bus.memRdata;
      end
    end
  end

  assign io_bus.cpuAck   = (r_state == CPU_RSP);
  assign io_bus.vidAck   = (r_state == VID_RSP);
  assign io_bus.cpuRdata = r_cpuRdata;
  assign io_bus.vidRdata = r_vidRdata;
  assign io_bus.memAddr  = w_memAddr;
  assign io_bus.memWdata = w_memWdata;
  assign io_bus.memWe    = w_memWe;

endmodule
